// File: rtl/io_circuits_pkg.sv
// io_circuits_pkg: timing constants shared by the synchronizer, debouncer and button/switch top level.
package io_circuits;
    localparam int SAMPLE_CNT_MAX = 62500;
    localparam int PULSE_CNT_MAX  = 200;
endpackage

// File: rtl/debouncer_edge_detector.sv
// edge_detector: one-cycle strobe per bit on each rising edge of signal_in.
module edge_detector #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] signal_in,
    output logic [WIDTH-1:0] edge_detect_pulse
);
    logic [WIDTH-1:0] prev_q;
    io_reg_r #(.N(WIDTH)) u_prev (.clk(clk), .rst(rst), .ce(1'b1), .d(signal_in), .q(prev_q));
    assign edge_detect_pulse = signal_in & ~prev_q;
endmodule

// File: rtl/io_reg_r.sv
// io_reg_r: resettable register with clock enable, asynchronous active-high reset.
module io_reg_r #(
    parameter int             N    = 1,
    parameter logic [N-1:0]   INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= INIT;
        else if (ce) q <= d;
endmodule

// File: rtl/debouncer.sv
// debouncer: per-bit saturating sample counters driven by a shared sample tick; level plus rising-edge pulse.
module debouncer
    import io_circuits::*;
#(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = io_circuits::SAMPLE_CNT_MAX,
    parameter int PULSE_CNT_MAX  = io_circuits::PULSE_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] debounced_pulse
);
    localparam int SW = $clog2(SAMPLE_CNT_MAX);
    localparam int PW = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [SW-1:0] SLAST = SW'(SAMPLE_CNT_MAX - 1);
    localparam logic [PW-1:0] PMAX  = PW'(PULSE_CNT_MAX);

    logic [SW-1:0] smp_q, smp_d;
    logic          tick;

    assign tick  = smp_q == SLAST;
    assign smp_d = tick ? '0 : smp_q + 1'b1;
    io_reg_r #(.N(SW)) u_smp (.clk(clk), .rst(rst), .ce(1'b1), .d(smp_d), .q(smp_q));

    // A low sample clears progress outright; a high sample counts up and sticks at PMAX.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [PW-1:0] cnt_q, cnt_d;
        assign cnt_d = !glitchy_signal[i] ? '0 : (cnt_q == PMAX) ? cnt_q : cnt_q + 1'b1;
        io_reg_r #(.N(PW)) u_cnt (.clk(clk), .rst(rst), .ce(tick), .d(cnt_d), .q(cnt_q));
        assign debounced_signal[i] = cnt_q == PMAX;
    end

    edge_detector #(.WIDTH(WIDTH)) u_edge (
        .clk(clk),
        .rst(rst),
        .signal_in(debounced_signal),
        .edge_detect_pulse(debounced_pulse)
    );
endmodule
